// File: rtl/wbr_input_chain_param_if.sv
// Wrapper serial-port bundle for the input boundary register.
// Carries the IEEE 1500 scan controls and the serial data path.
//   WSE  : shift enable
//   WCE  : capture enable
//   WUE  : update enable
//   WPSI : serial scan in, toward the boundary register
//   WPSO : serial scan out, from the boundary register
// The master modport belongs to whoever drives the scan controls, such as
// the WSP controller or a testbench. The slave modport belongs to the
// boundary register itself.
interface wbr_input_chain_param_if;
  logic WSE;
  logic WCE;
  logic WUE;
  logic WPSI;
  logic WPSO;

  modport master (
    output WSE,
    output WCE,
    output WUE,
    output WPSI,
    input  WPSO
  );

  modport slave (
    input  WSE,
    input  WCE,
    input  WUE,
    input  WPSI,
    output WPSO
  );
endinterface

// File: rtl/wbr_input_chain_param.sv
// Parametrised IEEE 1500 wrapper boundary register for core input signals.
// Each bit has a shift/capture cell (sr) and an update cell (ur).
// A mode mux chooses what the core sees.
//
// Ports:
//   CLK         : wrapper/functional clock; all state changes on the rising edge
//   RESET       : synchronous active-high reset (sr <= 0, ur <= RESET_UPD)
//   wsp         : slave side of the wrapper serial port (WSE/WCE/WUE/WPSI/WPSO)
//   hold_inputs : freezes the update register while high
//   mode        : 00 FUNC, 01 INTEST, 10 EXTEST, 11 SAFE
//   func_in     : functional sources for the core inputs
//   core_in     : values driven into the wrapped core
//   obs_out     : update-register contents, for observation
module wbr_input_chain_param #(
  parameter int               WIDTH      = 9,
  parameter logic [WIDTH-1:0] SAFE_VALUE = '0,
  parameter logic [WIDTH-1:0] RESET_UPD  = '0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  wbr_input_chain_param_if.slave wsp,
  input  logic                 hold_inputs,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     func_in,
  output logic [WIDTH-1:0]     core_in,
  output logic [WIDTH-1:0]     obs_out
);

  localparam logic [1:0] MODE_FUNC   = 2'b00;
  localparam logic [1:0] MODE_INTEST = 2'b01;
  localparam logic [1:0] MODE_EXTEST = 2'b10;
  localparam logic [1:0] MODE_SAFE   = 2'b11;

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] ur;
  logic [WIDTH-1:0] shift_next;

  // The shift value is built by shift-then-insert. This avoids the
  // sr[WIDTH-1:1] slice, which would be empty when WIDTH=1.
  always_comb begin
    shift_next            = sr >> 1;
    shift_next[WIDTH-1]   = wsp.WPSI;
  end

  // Shift has priority over capture. The update register samples the
  // pre-edge sr, so a shift and an update on the same edge hand the old
  // contents to ur.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sr <= '0;
      ur <= RESET_UPD;
    end else begin
      if (wsp.WSE)
        sr <= shift_next;
      else if (wsp.WCE)
        sr <= func_in;

      if (wsp.WUE && !hold_inputs)
        ur <= sr;
    end
  end

  // EXTEST passes functional values through to the core. In that mode the
  // update register is only observed, through obs_out.
  always_comb begin
    core_in = func_in;
    unique case (mode)
      MODE_FUNC:   core_in = func_in;
      MODE_INTEST: core_in = ur;
      MODE_EXTEST: core_in = func_in;
      MODE_SAFE:   core_in = SAFE_VALUE;
      default:     core_in = func_in;
    endcase
  end

  assign wsp.WPSO = sr[0];
  assign obs_out  = ur;

endmodule
